layer_output_serializer: RTL
============================

Name: layer_output_serializer

Overview:
- Sits between two neuron layers.
- Captures the dataWidth-bit outputs of all numNeuron neurons of one layer. Each neuron reports with its own valid strobe, and the strobes may be skewed.
- Streams the captured outputs one word per cycle, neuron 0 first, into the next layer's shared mInput/mInputValid bus.
- Double-buffered: the next layer's results can be collected while the previous vector is still streaming out. A ready input supports stalls.

Parameters:
numNeuron, 30, number of neurons in the upstream layer (>=2)
dataWidth, 16, width of each neuron output word
idxWidth, $clog2(numNeuron), width of the index counter (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
rstn  input  1  asynchronous active-low reset
in_data  input  numNeuron*dataWidth  neuron outputs; word i = bits [i*dataWidth +: dataWidth]
in_valid  input  numNeuron  per-neuron output valid strobe (the mOutputValid of each neuron)
out_data  output  dataWidth  serialized word (drives the next layer's mInput)
out_valid  output  1  out_data valid (drives the next layer's mInputValid)
out_ready  input  1  consumer accepts the word; tie to 1 when there is no backpressure
out_index  output  idxWidth  neuron index of the current out_data
out_last  output  1  high with the word of index numNeuron-1
busy  output  1  state is SHIFT
overrun  output  1  sticky error flag; cleared only by reset

Behaviour:
- Reset (async, rstn=0):
  - All outputs 0: out_data, out_valid, out_index, out_last, busy, overrun.
  - Capture mask, capture registers and shift buffer cleared; state IDLE.
  - Reset mid-stream aborts the vector; no partial data is resent.
- Capture stage:
  - When in_valid[i]=1: cap[i] <= word i and mask[i] <= 1.
  - If mask[i] is already 1 and no transfer happens this cycle, the new word is dropped (cap[i] keeps the old value) and overrun <= 1.
- Transfer:
  - Occurs when mask is all ones AND (state==IDLE OR the last beat is accepted this cycle).
  - Action: buf <= cap; mask <= in_valid, so a strobe in the transfer cycle starts the next vector and its word is written to cap; index <= 0; state <= SHIFT.
  - A strobe on any bit in the transfer cycle is not an overrun.
- FSM:
  - IDLE: out_valid=0. Go to SHIFT on transfer.
  - SHIFT: out_valid=1, out_data=buf[index], out_last=(index==numNeuron-1).
  - On out_valid&out_ready, a beat is accepted:
    - If index<numNeuron-1: index <= index+1.
    - If index==numNeuron-1: a transfer when mask is full (stay in SHIFT, back-to-back, no bubble); otherwise go to IDLE with index <= 0.
  - out_ready=0 holds out_data, out_index and out_valid stable.
- Latency:
  - The last strobe sampled at edge k sets the mask full; transfer happens at edge k+1; out_valid=1 after edge k+1.
  - A full vector with out_ready=1 occupies exactly numNeuron cycles.
- Outputs are registered. out_data and out_last derive from buf and the index register only; there is no combinational path from in_* to out_*.
- Arithmetic: data passes through unmodified (no sign handling). The index counter never exceeds numNeuron-1.

Test Plan:
- numNeuron=4, dataWidth=16. Strobe all in_valid=4'b1111 in one cycle with words 0x0001,0x0002,0x0003,0x0004; out_ready=1 -> out_valid rises 2 cycles later; then 0x0001..0x0004 on 4 consecutive cycles, out_index 0..3, out_last only on 0x0004; then IDLE, busy=0.
- Skewed strobes: bit0 at t0, bit2 at t1, bits1,3 at t3 (words 0xA0,0xA1,0xA2,0xA3) -> no output before t3+2; stream is 0xA0,0xA1,0xA2,0xA3 in index order.
- Backpressure: out_ready low for 3 cycles while index=1 -> out_data=word1 and out_index=1 held; stream resumes with word2 and no word is lost or duplicated.
- Back-to-back: second vector 0x10..0x13 completes while the first is streaming -> 0x0001..0x0004 followed immediately by 0x10..0x13 with out_valid continuously 1 for 8 cycles.
- Overrun: in_valid[1] strobes twice (0x55, then 0x66) before bits 0,2,3 arrive -> overrun=1 and stays 1; streamed word1=0x55.
- Reset mid-stream: assert rstn=0 at index=2 -> all outputs 0 immediately. After release, a fresh vector streams correctly from index 0.

Source files
------------

// File: rtl/layer_output_serializer_if.sv
// ---------------------------------------------------------------------------
// layer_output_serializer_if
//   Bus bundle between one neuron layer, the layer output serializer and the
//   shared input bus of the next layer.
//
//   in_data   : all neuron output words packed, word i = [i*dataWidth +: dataWidth]
//   in_valid  : per-neuron output valid strobe
//   out_data  : serialized word towards the next layer (mInput)
//   out_valid : out_data valid (mInputValid)
//   out_ready : consumer accepts the current word
//   out_index : neuron index of the word on out_data
//   out_last  : high with the word of the highest neuron index
//
//   master : upstream layer + downstream consumer side (drives in_*, out_ready)
//   slave  : serializer side
// ---------------------------------------------------------------------------
interface layer_output_serializer_if #(
  parameter int numNeuron = 30,
  parameter int dataWidth = 16
);
  localparam int idxWidth = $clog2(numNeuron);

  logic [numNeuron*dataWidth-1:0] in_data;
  logic [numNeuron-1:0]           in_valid;
  logic [dataWidth-1:0]           out_data;
  logic                           out_valid;
  logic                           out_ready;
  logic [idxWidth-1:0]            out_index;
  logic                           out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  out_data, out_valid, out_index, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output out_data, out_valid, out_index, out_last
  );
endinterface

// File: rtl/layer_output_serializer.sv
// ---------------------------------------------------------------------------
// layer_output_serializer
//   Collects the outputs of all numNeuron neurons of one layer (each with its
//   own, possibly skewed, valid strobe) and streams them one word per cycle,
//   neuron 0 first, onto the next layer's shared input bus. Double-buffered:
//   a capture stage gathers the next vector while the shift buffer streams
//   the previous one; completed vectors move across with no bubble.
//
//   clk     : rising-edge clock
//   rstn    : asynchronous active-low reset
//   bus     : serializer side of layer_output_serializer_if
//   busy    : high while a vector is being streamed (state SHIFT)
//   overrun : sticky; a neuron reported again before its previous word was
//             handed to the shift buffer (the new word is dropped)
// ---------------------------------------------------------------------------
module layer_output_serializer #(
  parameter int numNeuron = 30,
  parameter int dataWidth = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  layer_output_serializer_if.slave  bus,
  output logic                      busy,
  output logic                      overrun
);

  localparam int idxWidth = $clog2(numNeuron);
  localparam logic [idxWidth-1:0] LastIdx = idxWidth'(numNeuron - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [idxWidth-1:0]  idx_q, idx_d;
  logic [numNeuron-1:0] mask_q, mask_d;
  logic                 overrun_q, overrun_d;
  logic [dataWidth-1:0] cap_q   [numNeuron];
  logic [dataWidth-1:0] cap_d   [numNeuron];
  logic [dataWidth-1:0] shbuf_q [numNeuron];
  logic [dataWidth-1:0] shbuf_d [numNeuron];

  logic mask_full;
  logic beat_acc;
  logic last_acc;
  logic transfer;

  // Handshake qualifiers. A transfer needs a complete capture vector and a
  // free shift buffer: either nothing is streaming, or the final beat of the
  // current vector leaves this very cycle.
  always_comb begin
    mask_full = &mask_q;
    beat_acc  = (state_q == SHIFT) && bus.out_ready;
    last_acc  = beat_acc && (idx_q == LastIdx);
    transfer  = mask_full && ((state_q == IDLE) || last_acc);
  end

  // Capture stage, shift buffer load and FSM next state.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mask_d    = mask_q;
    overrun_d = overrun_q;
    cap_d     = cap_q;
    shbuf_d   = shbuf_q;

    for (int i = 0; i < numNeuron; i++) begin
      if (transfer) begin
        // The mask restarts from this cycle's strobes so a neuron reporting
        // during the transfer already belongs to the next vector.
        mask_d[i] = bus.in_valid[i];
        if (bus.in_valid[i]) begin
          cap_d[i] = bus.in_data[i*dataWidth +: dataWidth];
        end
      end else if (bus.in_valid[i]) begin
        if (mask_q[i]) begin
          overrun_d = 1'b1;
        end else begin
          cap_d[i]  = bus.in_data[i*dataWidth +: dataWidth];
          mask_d[i] = 1'b1;
        end
      end
    end

    if (transfer) begin
      shbuf_d = cap_q;
    end

    unique case (state_q)
      IDLE: begin
        if (transfer) begin
          state_d = SHIFT;
          idx_d   = '0;
        end
      end
      SHIFT: begin
        if (beat_acc) begin
          if (idx_q != LastIdx) begin
            idx_d = idx_q + idxWidth'(1);
          end else if (transfer) begin
            state_d = SHIFT;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
            idx_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      mask_q    <= '0;
      overrun_q <= 1'b0;
      cap_q     <= '{default: '0};
      shbuf_q   <= '{default: '0};
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mask_q    <= mask_d;
      overrun_q <= overrun_d;
      cap_q     <= cap_d;
      shbuf_q   <= shbuf_d;
    end
  end

  // Outputs come only from registered state; nothing from in_* reaches them
  // combinationally.
  assign bus.out_valid = (state_q == SHIFT);
  assign bus.out_data  = (state_q == SHIFT) ? shbuf_q[idx_q] : '0;
  assign bus.out_index = idx_q;
  assign bus.out_last  = (state_q == SHIFT) && (idx_q == LastIdx);
  assign busy          = (state_q == SHIFT);
  assign overrun       = overrun_q;

endmodule
